irq_priority_controller: RTL and testbench

//  Multi-source machine-mode interrupt controller for the RV32 core; successor of the single-source controller.

---
 rtl/irq_priority_controller.sv | 117 +++++++++++
 tb/tb_irq_priority_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_controller.sv
// Fixed-priority multi-source machine-mode interrupt controller for the RV32 core.
// Tracks interrupt/exception nesting so mret_i reports whether it leaves an interrupt.
module irq_priority_controller #(
  parameter int unsigned        N_SRC      = 16,
  parameter logic [N_SRC-1:0]   EDGE_MASK  = '0,
  parameter logic [31:0]        CAUSE_BASE = 32'h8000_0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exception_i,
  input  logic [N_SRC-1:0] irq_req_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             mie_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_SRC-1:0] irq_ack_o,
  output logic             irq_ret_o
);

  localparam int unsigned ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXC,
    S_IRQ,
    S_IRQ_EXC
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend_edge;
  logic [ID_W-1:0]  r_id;

  logic [N_SRC-1:0] w_pend;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_onehot;
  logic [N_SRC-1:0] w_edge_nxt;
  logic [ID_W-1:0]  w_winner;
  logic             w_any;

  assign w_pend = (irq_req_i & ~EDGE_MASK) | (r_pend_edge & EDGE_MASK);
  assign w_elig = w_pend & irq_mask_i;
  assign w_any  = |w_elig;

  // Scanning downward leaves the lowest set index as the winner.
  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_winner = '0;
    w_onehot = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = ID_W'(i);
    end
    w_onehot[w_winner] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    irq_o       = 1'b0;
    irq_ret_o   = 1'b0;
    irq_cause_o = CAUSE_BASE | 32'(r_id);
    case (r_state)
      S_IDLE: begin
        irq_cause_o = CAUSE_BASE | 32'(w_winner);
        if (exception_i) begin
          w_state_nxt = S_EXC;
        end else if (mie_i && w_any) begin
          irq_o       = 1'b1;
          w_state_nxt = S_IRQ;
        end
      end
      S_EXC: begin
        if (!exception_i && mret_i) w_state_nxt = S_IDLE;
      end
      S_IRQ: begin
        if (exception_i) begin
          w_state_nxt = S_IRQ_EXC;
        end else if (mret_i) begin
          irq_ret_o   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_IRQ_EXC: begin
        if (!exception_i && mret_i) w_state_nxt = S_IRQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Level requests are visible during reset; keep the outputs quiet until release.
    if (rst_i) begin
      irq_o       = 1'b0;
      irq_ret_o   = 1'b0;
      irq_cause_o = CAUSE_BASE;
    end
  end

  assign irq_ack_o = irq_o ? w_onehot : '0;

  // A fresh edge in the ack cycle re-arms the pending bit.
  assign w_edge_nxt = ((r_pend_edge & ~irq_ack_o) | (irq_req_i & ~r_prev)) & EDGE_MASK;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_pend_edge <= '0;
      r_id        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= irq_req_i;
      r_pend_edge <= w_edge_nxt;
      if (irq_o) r_id <= w_winner;
    end
  end

endmodule

// File: tb/tb_irq_priority_controller.sv
// Scoreboard bench for irq_priority_controller: expectations are queued as stimulus
// is driven, DUT outputs are captured mid-cycle, and each scenario drains and compares.
module tb_irq_priority_controller;

  localparam logic [31:0] CB  = 32'h8000_0010;
  localparam logic [15:0] ALL = 16'hFFFF;

  typedef struct packed {
    logic        irq;
    logic        ret;
    logic [15:0] ack;
    logic [31:0] cause;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        exception_i = 1'b0;
  logic [15:0] irq_req_i = '0;
  logic [15:0] irq_mask_i = ALL;
  logic        mie_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ack_o;
  logic        irq_ret_o;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  irq_priority_controller #(
    .N_SRC     (16),
    .EDGE_MASK (16'h0020),
    .CAUSE_BASE(CB)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .exception_i(exception_i),
    .irq_req_i  (irq_req_i),
    .irq_mask_i (irq_mask_i),
    .mie_i      (mie_i),
    .mret_i     (mret_i),
    .irq_o      (irq_o),
    .irq_cause_o(irq_cause_o),
    .irq_ack_o  (irq_ack_o),
    .irq_ret_o  (irq_ret_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(input logic irq, input logic ret, input logic [15:0] ack,
                              input logic [31:0] cause);
    obs_t e;
    e.irq = irq; e.ret = ret; e.ack = ack; e.cause = cause;
    return e;
  endfunction

  task automatic capture(input string tag, input obs_t exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    obs_q.push_back({irq_o, irq_ret_o, irq_ack_o, irq_cause_o});
  endtask

  task automatic step(input string tag, input logic rst, input logic exc, input logic mret,
                      input logic mie, input logic [15:0] req, input logic [15:0] mask,
                      input obs_t exp);
    @(negedge clk);
    rst_i = rst; exception_i = exc; mret_i = mret; mie_i = mie;
    irq_req_i = req; irq_mask_i = mask;
    capture(tag, exp);
  endtask

  task automatic test_reset();
    obs_t e, o; string t;
    step("rst_hold0", 1, 0, 0, 1, ALL, ALL, ex(0, 0, 16'h0, CB));
    step("rst_hold1", 1, 0, 0, 1, ALL, ALL, ex(0, 0, 16'h0, CB));
    step("rst_first", 0, 0, 0, 1, ALL, ALL, ex(1, 0, 16'h0001, CB));
    step("rst_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB));
    step("edge_from_rst", 0, 0, 0, 1, 16'h0, ALL, ex(1, 0, 16'h0020, CB | 32'd5));
    step("edge_from_rst_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd5));
    step("rst_idle", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  task automatic test_level_priority();
    obs_t e, o; string t;
    step("prio_fire", 0, 0, 0, 1, 16'h0028, ALL, ex(1, 0, 16'h0008, CB | 32'd3));
    step("prio_hold", 0, 0, 0, 1, 16'h0028, ALL, ex(0, 0, 16'h0, CB | 32'd3));
    step("prio_mret", 0, 0, 1, 1, 16'h0028, ALL, ex(0, 1, 16'h0, CB | 32'd3));
    step("prio_refire", 0, 0, 0, 1, 16'h0008, ALL, ex(1, 0, 16'h0008, CB | 32'd3));
    step("prio_mret2", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd3));
    step("prio_edge", 0, 0, 0, 1, 16'h0, ALL, ex(1, 0, 16'h0020, CB | 32'd5));
    step("prio_edge_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd5));
    step("prio_idle", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  task automatic test_nesting();
    obs_t e, o; string t;
    step("nest_fire", 0, 0, 0, 1, 16'h0008, ALL, ex(1, 0, 16'h0008, CB | 32'd3));
    step("nest_exc", 0, 1, 0, 1, 16'h0001, ALL, ex(0, 0, 16'h0, CB | 32'd3));
    step("nest_mret1", 0, 0, 1, 1, 16'h0001, ALL, ex(0, 0, 16'h0, CB | 32'd3));
    step("nest_exc_mret", 0, 1, 1, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB | 32'd3));
    step("nest_mret_b", 0, 0, 1, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB | 32'd3));
    step("nest_mret2", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd3));
    step("nest_idle", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  task automatic test_edge_pending();
    obs_t e, o; string t;
    step("edge_pulse", 0, 0, 0, 0, 16'h0020, ALL, ex(0, 0, 16'h0, CB));
    for (int i = 0; i < 9; i++)
      step("edge_wait", 0, 0, 0, 0, 16'h0, ALL, ex(0, 0, 16'h0, CB | 32'd5));
    step("edge_enable", 0, 0, 0, 1, 16'h0, ALL, ex(1, 0, 16'h0020, CB | 32'd5));
    step("edge_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd5));
    step("edge_no_refire", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    step("mask_pulse", 0, 0, 0, 1, 16'h0020, 16'hFFDF, ex(0, 0, 16'h0, CB));
    for (int i = 0; i < 3; i++)
      step("mask_wait", 0, 0, 0, 1, 16'h0, 16'hFFDF, ex(0, 0, 16'h0, CB));
    step("mask_enable", 0, 0, 0, 1, 16'h0020, ALL, ex(1, 0, 16'h0020, CB | 32'd5));
    step("mask_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd5));
    step("ack_edge_refire", 0, 0, 0, 1, 16'h0, ALL, ex(1, 0, 16'h0020, CB | 32'd5));
    step("ack_edge_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB | 32'd5));
    step("edge_idle", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  task automatic test_level_drop();
    obs_t e, o; string t;
    step("drop_blocked", 0, 0, 0, 0, 16'h0004, ALL, ex(0, 0, 16'h0, CB | 32'd2));
    step("drop_lost", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  // The last serviced source before this scenario is 5, so EXC reports that id.
  task automatic test_exception();
    obs_t e, o; string t;
    step("exc_with_req", 0, 1, 0, 1, 16'h0001, ALL, ex(0, 0, 16'h0, CB));
    step("exc_nested", 0, 1, 0, 1, 16'h0001, ALL, ex(0, 0, 16'h0, CB | 32'd5));
    step("exc_mret", 0, 0, 1, 1, 16'h0001, ALL, ex(0, 0, 16'h0, CB | 32'd5));
    step("exc_refire", 0, 0, 0, 1, 16'h0001, ALL, ex(1, 0, 16'h0001, CB));
    step("exc_irq_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 1, 16'h0, CB));
    step("exc_idle", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o; string t;
    step("ar_fire", 0, 0, 0, 1, 16'h0024, ALL, ex(1, 0, 16'h0004, CB | 32'd2));
    @(negedge clk);
    irq_req_i = 16'h0; mret_i = 1'b1;
    capture("ar_in_irq", ex(0, 1, 16'h0, CB | 32'd2));
    #2 rst_i = 1'b1;
    capture("ar_async", ex(0, 0, 16'h0, CB));
    @(negedge clk);
    capture("ar_held", ex(0, 0, 16'h0, CB));
    step("ar_release_mret", 0, 0, 1, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    step("ar_edge_cleared", 0, 0, 0, 1, 16'h0, ALL, ex(0, 0, 16'h0, CB));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got irq=%b ret=%b ack=%h cause=%h, want irq=%b ret=%b ack=%h cause=%h",
                 t, o.irq, o.ret, o.ack, o.cause, e.irq, e.ret, e.ack, e.cause);
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_priority();
    test_nesting();
    test_edge_pending();
    test_level_drop();
    test_exception();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
